// File: rtl/alu_instr_decoder_if.sv
// Instruction-in / decoded-controls-out bundle for alu_instr_decoder.
// The producer of instructions uses the master modport; the decoder uses the slave modport.
interface alu_instr_decoder_if #(
  parameter int unsigned CONTROL_BITS  = 3,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
);
  logic [31:0]              instr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic                     ALUSrc;
  logic [CONTROL_BITS-1:0]  ALUControl;
  logic                     RegWrite;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     issue;
  logic                     illegal;
  logic [15:0]              issue_count;
  logic [7:0]               illegal_count;

  modport master (
    output instr, instr_valid,
    input  instr_ready, ImmOp, ALUSrc, ALUControl, RegWrite,
           rs1, rs2, rd, issue, illegal, issue_count, illegal_count
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, ImmOp, ALUSrc, ALUControl, RegWrite,
           rs1, rs2, rd, issue, illegal, issue_count, illegal_count
  );
endinterface

// File: rtl/alu_instr_decoder.sv
// RV32I ALU-subset decoder: accepts one instruction, presents registered controls
// for one ISSUE cycle (issue pulse), then holds the decoded fields until the next accept.
module alu_instr_decoder #(
  parameter int unsigned CONTROL_BITS  = 3,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input logic                clk,
  input logic                rst_n,
  alu_instr_decoder_if.slave bus
);

  localparam int unsigned ISSUE_CNT_W = 16;
  localparam int unsigned ILL_CNT_W   = 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [CONTROL_BITS-1:0] ALU_ADD = CONTROL_BITS'(3'b000);
  localparam logic [CONTROL_BITS-1:0] ALU_SUB = CONTROL_BITS'(3'b001);
  localparam logic [CONTROL_BITS-1:0] ALU_AND = CONTROL_BITS'(3'b010);
  localparam logic [CONTROL_BITS-1:0] ALU_OR  = CONTROL_BITS'(3'b011);
  localparam logic [CONTROL_BITS-1:0] ALU_SLT = CONTROL_BITS'(3'b101);

  logic [0:0]               r_state;
  logic                     r_ready;
  logic                     r_issue;
  logic                     r_illegal;
  logic                     r_reg_write;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic                     r_alu_src;
  logic [CONTROL_BITS-1:0]  r_alu_ctrl;
  logic [ADDRESS_WIDTH-1:0] r_rs1;
  logic [ADDRESS_WIDTH-1:0] r_rs2;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [ISSUE_CNT_W-1:0]   r_issue_cnt;
  logic [ILL_CNT_W-1:0]     r_ill_cnt;

  logic                     w_legal;
  logic [DATA_WIDTH-1:0]    w_imm;
  logic                     w_alu_src;
  logic [CONTROL_BITS-1:0]  w_alu_ctrl;
  logic [ADDRESS_WIDTH-1:0] w_rs1;
  logic [ADDRESS_WIDTH-1:0] w_rs2;
  logic [ADDRESS_WIDTH-1:0] w_rd;

  logic [0:0]               w_next_state;
  logic                     w_next_ready;
  logic                     w_next_issue;
  logic                     w_next_illegal;
  logic                     w_next_reg_write;
  logic [DATA_WIDTH-1:0]    w_next_imm;
  logic                     w_next_alu_src;
  logic [CONTROL_BITS-1:0]  w_next_alu_ctrl;
  logic [ADDRESS_WIDTH-1:0] w_next_rs1;
  logic [ADDRESS_WIDTH-1:0] w_next_rs2;
  logic [ADDRESS_WIDTH-1:0] w_next_rd;
  logic [ISSUE_CNT_W-1:0]   w_next_issue_cnt;
  logic [ILL_CNT_W-1:0]     w_next_ill_cnt;

  // Pure decode of the incoming word; unsupported encodings fall through to the zeroed defaults.
  always_comb begin
    w_legal    = 1'b0;
    w_imm      = '0;
    w_alu_src  = 1'b0;
    w_alu_ctrl = ALU_ADD;
    w_rs1      = ADDRESS_WIDTH'(bus.instr[19:15]);
    w_rs2      = ADDRESS_WIDTH'(bus.instr[24:20]);
    w_rd       = ADDRESS_WIDTH'(bus.instr[11:7]);
    case (bus.instr[6:0])
      OP_R: begin
        case ({bus.instr[31:25], bus.instr[14:12]})
          10'b0000000_000: begin w_legal = 1'b1; w_alu_ctrl = ALU_ADD; end
          10'b0100000_000: begin w_legal = 1'b1; w_alu_ctrl = ALU_SUB; end
          10'b0000000_010: begin w_legal = 1'b1; w_alu_ctrl = ALU_SLT; end
          10'b0000000_110: begin w_legal = 1'b1; w_alu_ctrl = ALU_OR;  end
          10'b0000000_111: begin w_legal = 1'b1; w_alu_ctrl = ALU_AND; end
          default: ;
        endcase
      end
      OP_I: begin
        case (bus.instr[14:12])
          3'b000: begin w_legal = 1'b1; w_alu_ctrl = ALU_ADD; end
          3'b010: begin w_legal = 1'b1; w_alu_ctrl = ALU_SLT; end
          3'b110: begin w_legal = 1'b1; w_alu_ctrl = ALU_OR;  end
          3'b111: begin w_legal = 1'b1; w_alu_ctrl = ALU_AND; end
          default: ;
        endcase
        if (w_legal) begin
          w_alu_src = 1'b1;
          w_imm     = DATA_WIDTH'($signed(bus.instr[31:20]));
          w_rs2     = '0;
        end
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic; decoded fields only change on acceptance.
  always_comb begin
    w_next_state     = r_state;
    w_next_ready     = 1'b1;
    w_next_issue     = 1'b0;
    w_next_illegal   = 1'b0;
    w_next_reg_write = 1'b0;
    w_next_imm       = r_imm;
    w_next_alu_src   = r_alu_src;
    w_next_alu_ctrl  = r_alu_ctrl;
    w_next_rs1       = r_rs1;
    w_next_rs2       = r_rs2;
    w_next_rd        = r_rd;
    w_next_issue_cnt = r_issue_cnt;
    w_next_ill_cnt   = r_ill_cnt;
    case (r_state)
      IDLE: begin
        if (bus.instr_valid) begin
          w_next_state     = ISSUE;
          w_next_ready     = 1'b0;
          w_next_issue     = 1'b1;
          w_next_illegal   = ~w_legal;
          w_next_reg_write = w_legal && (w_rd != '0);
          w_next_imm       = w_imm;
          w_next_alu_src   = w_alu_src;
          w_next_alu_ctrl  = w_alu_ctrl;
          w_next_rs1       = w_rs1;
          w_next_rs2       = w_rs2;
          w_next_rd        = w_rd;
          w_next_issue_cnt = r_issue_cnt + ISSUE_CNT_W'(1);
          if (!w_legal && (r_ill_cnt != {ILL_CNT_W{1'b1}})) begin
            w_next_ill_cnt = r_ill_cnt + ILL_CNT_W'(1);
          end
        end
      end
      ISSUE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_issue     <= 1'b0;
      r_illegal   <= 1'b0;
      r_reg_write <= 1'b0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_issue_cnt <= '0;
      r_ill_cnt   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_ready     <= w_next_ready;
      r_issue     <= w_next_issue;
      r_illegal   <= w_next_illegal;
      r_reg_write <= w_next_reg_write;
      r_imm       <= w_next_imm;
      r_alu_src   <= w_next_alu_src;
      r_alu_ctrl  <= w_next_alu_ctrl;
      r_rs1       <= w_next_rs1;
      r_rs2       <= w_next_rs2;
      r_rd        <= w_next_rd;
      r_issue_cnt <= w_next_issue_cnt;
      r_ill_cnt   <= w_next_ill_cnt;
    end
  end

  assign bus.instr_ready   = r_ready;
  assign bus.issue         = r_issue;
  assign bus.illegal       = r_illegal;
  assign bus.RegWrite      = r_reg_write;
  assign bus.ImmOp         = r_imm;
  assign bus.ALUSrc        = r_alu_src;
  assign bus.ALUControl    = r_alu_ctrl;
  assign bus.rs1           = r_rs1;
  assign bus.rs2           = r_rs2;
  assign bus.rd            = r_rd;
  assign bus.issue_count   = r_issue_cnt;
  assign bus.illegal_count = r_ill_cnt;

endmodule

// File: tb/tb_alu_instr_decoder.sv
// Directed-vector bench for alu_instr_decoder; inputs driven and outputs sampled on the falling edge.
module tb_alu_instr_decoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_issue;

  alu_instr_decoder_if bus ();

  alu_instr_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One-cycle valid pulse; returns at the falling edge inside the ISSUE cycle.
  task automatic accept(input logic [31:0] w);
    @(negedge clk);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    exp_issue++;
  endtask

  task automatic check_fields(input string tag, input logic [31:0] imm, input logic src,
                              input logic [2:0] ctrl, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd);
    check({tag, ".imm"},  bus.ImmOp,               imm);
    check({tag, ".src"},  32'(bus.ALUSrc),         32'(src));
    check({tag, ".ctrl"}, 32'(bus.ALUControl),     32'(ctrl));
    check({tag, ".rs1"},  32'(bus.rs1),            32'(rs1));
    check({tag, ".rs2"},  32'(bus.rs2),            32'(rs2));
    check({tag, ".rd"},   32'(bus.rd),             32'(rd));
  endtask

  task automatic check_pulse(input string tag, input logic iss, input logic ill, input logic rw);
    check({tag, ".issue"},   32'(bus.issue),    32'(iss));
    check({tag, ".illegal"}, 32'(bus.illegal),  32'(ill));
    check({tag, ".regwr"},   32'(bus.RegWrite), 32'(rw));
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    exp_issue       = 0;
    rst_n           = 1'b0;
    bus.instr       = 32'h0;
    bus.instr_valid = 1'b0;

    #12;
    check("rst.ready", 32'(bus.instr_ready), 32'h1);
    check_pulse("rst", 1'b0, 1'b0, 1'b0);
    check_fields("rst", 32'h0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
    check("rst.icnt", 32'(bus.issue_count), 32'h0);
    check("rst.lcnt", 32'(bus.illegal_count), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // addi x5,x0,-3
    accept(32'hFFD00293);
    check_pulse("addi", 1'b1, 1'b0, 1'b1);
    check_fields("addi", 32'hFFFF_FFFD, 1'b1, 3'b000, 5'd0, 5'd0, 5'd5);
    check("addi.ready", 32'(bus.instr_ready), 32'h0);
    check("addi.icnt", 32'(bus.issue_count), 32'd1);
    @(negedge clk);
    check_pulse("addi.after", 1'b0, 1'b0, 1'b0);
    check("addi.after.ready", 32'(bus.instr_ready), 32'h1);
    @(negedge clk);
    check_fields("addi.hold", 32'hFFFF_FFFD, 1'b1, 3'b000, 5'd0, 5'd0, 5'd5);

    // sub x3,x1,x2
    accept(32'h402081B3);
    check_pulse("sub", 1'b1, 1'b0, 1'b1);
    check_fields("sub", 32'h0, 1'b0, 3'b001, 5'd1, 5'd2, 5'd3);

    // all-zero word is illegal
    accept(32'h00000000);
    check_pulse("zero", 1'b1, 1'b1, 1'b0);
    check_fields("zero", 32'h0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
    check("zero.lcnt", 32'(bus.illegal_count), 32'd1);

    // add x0,x1,x2: legal but no write to x0
    accept(32'h00208033);
    check_pulse("addx0", 1'b1, 1'b0, 1'b0);
    check_fields("addx0", 32'h0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd0);

    // slt x4,x1,x2
    accept(32'h0020A233);
    check_pulse("slt", 1'b1, 1'b0, 1'b1);
    check_fields("slt", 32'h0, 1'b0, 3'b101, 5'd1, 5'd2, 5'd4);

    // andi x7,x6,0xF0
    accept(32'h0F037393);
    check_pulse("andi", 1'b1, 1'b0, 1'b1);
    check_fields("andi", 32'h0000_00F0, 1'b1, 3'b010, 5'd6, 5'd0, 5'd7);

    // ori x8,x1,0x7FF (largest positive immediate)
    accept(32'h7FF0E413);
    check_pulse("ori", 1'b1, 1'b0, 1'b1);
    check_fields("ori", 32'h0000_07FF, 1'b1, 3'b011, 5'd1, 5'd0, 5'd8);

    // funct7=0100000 with funct3=010 is not a supported R-type
    accept(32'h4020A233);
    check_pulse("badr", 1'b1, 1'b1, 1'b0);
    check_fields("badr", 32'h0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd4);
    check("badr.lcnt", 32'(bus.illegal_count), 32'd2);
    check("badr.icnt", 32'(bus.issue_count), 32'(exp_issue));

    // illegal counter saturates
    for (int i = 0; i < 300; i++) accept(32'h00000000);
    check("sat.lcnt", 32'(bus.illegal_count), 32'hFF);
    check("sat.icnt", 32'(bus.issue_count), 32'(exp_issue));

    // back-to-back with valid held high
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n           = 1'b1;
    bus.instr       = 32'h402081B3;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    check("b2b.1.ready", 32'(bus.instr_ready), 32'h0);
    check("b2b.1.issue", 32'(bus.issue), 32'h1);
    check("b2b.1.rd", 32'(bus.rd), 32'd3);
    bus.instr = 32'hFFD00293;
    @(negedge clk);
    check("b2b.gap.issue", 32'(bus.issue), 32'h0);
    check("b2b.gap.ready", 32'(bus.instr_ready), 32'h1);
    check("b2b.gap.rd", 32'(bus.rd), 32'd3);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("b2b.2.ready", 32'(bus.instr_ready), 32'h0);
    check("b2b.2.issue", 32'(bus.issue), 32'h1);
    check("b2b.2.rd", 32'(bus.rd), 32'd5);
    check("b2b.icnt", 32'(bus.issue_count), 32'd2);

    // reset mid-ISSUE aborts without a clock edge
    accept(32'hFFD00293);
    check("abort.pre.regwr", 32'(bus.RegWrite), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_pulse("abort", 1'b0, 1'b0, 1'b0);
    check("abort.ready", 32'(bus.instr_ready), 32'h1);
    check("abort.icnt", 32'(bus.issue_count), 32'h0);
    check("abort.lcnt", 32'(bus.illegal_count), 32'h0);
    check("abort.imm", bus.ImmOp, 32'h0);

    // first edge after release accepts
    @(negedge clk);
    rst_n           = 1'b1;
    bus.instr       = 32'h402081B3;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check_pulse("post", 1'b1, 1'b0, 1'b1);
    check("post.ctrl", 32'(bus.ALUControl), 32'h1);
    check("post.icnt", 32'(bus.issue_count), 32'd1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
